// File: rtl/usrt_rx_shifter.sv
// usrt_rx_shifter: oversampled USRT receive deframer feeding the Rx data register
module usrt_rx_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Pclk,
  input  logic                  i_Reset,
  input  logic                  i_Sclk,
  input  logic                  i_Rxd,
  input  logic                  i_ParEn,
  input  logic                  i_ParOdd,
  input  logic                  i_Full,
  input  logic                  i_ClrOvr,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Push,
  output logic                  o_ParErr,
  output logic                  o_FrmErr,
  output logic                  o_Ovr,
  output logic                  o_Busy
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, rxd_sync;
  logic                    sclk_prev, par_en, par_odd, par_bit;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [CW-1:0]           cnt;
  logic                    sample, bit_in;
  assign sample = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign bit_in = rxd_sync[SYNC_STAGES-1];
  assign o_Busy = state != IDLE;
  // Sclk and Rxd share the same depth so the sampled bit lines up with its edge
  always_ff @(posedge i_Pclk or negedge i_Reset)
    if (!i_Reset) begin
      sclk_sync <= '0;
      rxd_sync  <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_Sclk};
      rxd_sync  <= {rxd_sync[SYNC_STAGES-2:0], i_Rxd};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  always_ff @(posedge i_Pclk or negedge i_Reset)
    if (!i_Reset) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      par_bit  <= 1'b0;
      o_Data   <= '0;
      o_Push   <= 1'b0;
      o_ParErr <= 1'b0;
      o_FrmErr <= 1'b0;
      o_Ovr    <= 1'b0;
    end else begin
      o_Push <= 1'b0;
      if (i_ClrOvr) o_Ovr <= 1'b0;
      if (sample)
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            cnt     <= '0;
            par_en  <= i_ParEn;
            par_odd <= i_ParOdd;
          end
          DATA: begin
            shreg <= {bit_in, shreg[DATA_WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) state <= par_en ? PARITY : STOP;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP: begin
            o_FrmErr <= !bit_in;
            o_ParErr <= par_en & ((^shreg ^ par_bit) != par_odd);
            state    <= bit_in ? IDLE : BREAK;
            if (bit_in && !i_Full) begin
              o_Data <= shreg;
              o_Push <= 1'b1;
            end
            if (bit_in && i_Full) o_Ovr <= 1'b1;
          end
          BREAK: if (bit_in) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: doc/usrt_rx_shifter.md
Name: usrt_rx_shifter

Overview:
- Serial-to-parallel receive stage of the USRT, directly upstream of the Rx data register.
- Samples the serial line on rising edges of the externally supplied USRT bit clock, which is oversampled in the peripheral clock domain.
- Deframes start/data/optional parity/stop, checks errors, and pushes each good byte into the Rx data register with a one-cycle push pulse.
- Respects the register's full flag and reports overrun.

Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first; must match the Rx data register width.
- SYNC_STAGES, 2, flip-flop synchronizer depth applied to both i_Sclk and i_Rxd; minimum 2.

Ports:
- i_Pclk  input  1  peripheral clock, the single clock of the block.
- i_Reset  input  1  asynchronous, active-low reset.
- i_Sclk  input  1  USRT bit clock, asynchronous to i_Pclk; period at least 4 i_Pclk.
- i_Rxd  input  1  serial receive line, idle high.
- i_ParEn  input  1  1 = a parity bit follows the data bits.
- i_ParOdd  input  1  1 = odd parity, 0 = even; ignored when i_ParEn = 0.
- i_Full  input  1  full flag from the Rx data register.
- i_ClrOvr  input  1  single-cycle clear of o_Ovr.
- o_Data  output  DATA_WIDTH  assembled byte, connects to the register's data input.
- o_Push  output  1  one-i_Pclk pulse, connects to the register's push input.
- o_ParErr  output  1  parity status of the last completed frame.
- o_FrmErr  output  1  stop-bit status of the last completed frame.
- o_Ovr  output  1  sticky overrun flag.
- o_Busy  output  1  high while a frame is in progress (state other than IDLE).

Behaviour:
- Reset (i_Reset = 0, asynchronous): state IDLE; all outputs 0; shift register, bit counter and synchronizers cleared. i_Rxd synchronizers reset to 1.
- Reset mid-frame: the partial frame is discarded and no push occurs.
- Sampling:
  - i_Sclk and i_Rxd pass through identical SYNC_STAGES synchronizers.
  - A sample event is the i_Pclk cycle where synced Sclk = 1 and its registered previous value = 0.
  - At a sample event the synced Rxd value is the sampled bit. Nothing happens outside sample events.
- State machine:
  - IDLE: sample event with bit = 0 → DATA, bit counter = 0. Bit = 1 → stay in IDLE.
  - DATA: each sample event shifts the bit in, LSB first (shift right, new bit into the MSB). Counter increments. After the DATA_WIDTH-th bit → PARITY if i_ParEn, else STOP.
  - PARITY: one sample event stores the parity bit → STOP.
  - STOP: one sample event evaluates the frame (see frame end), then:
    - stop bit = 1 → IDLE.
    - stop bit = 0 → BREAK.
  - BREAK: stays until a sample event sees bit = 1 → IDLE. That 1 bit is not treated as a start bit.
- i_ParEn and i_ParOdd are latched when leaving IDLE; changes mid-frame have no effect until the next frame.
- Frame end (the cycle after the STOP sample event):
  - o_FrmErr = (stop bit == 0).
  - o_ParErr = i_ParEn and (XOR(data, parity bit) != i_ParOdd). It is 0 when parity is disabled.
  - o_FrmErr and o_ParErr hold until the next frame end.
  - If stop bit = 1 and i_Full = 0: o_Data updated and o_Push = 1 for exactly one cycle. Parity-error frames are still pushed.
  - If stop bit = 1 and i_Full = 1: no push, o_Ovr set, o_Data unchanged.
  - If stop bit = 0: no push; o_Ovr unaffected.
- o_Data holds its last pushed value between pushes.
- o_Ovr: sticky. Cleared by i_ClrOvr. A simultaneous set and clear resolves to set.
- Latency: o_Push rises 1 i_Pclk after the STOP sample event. The sample event itself occurs SYNC_STAGES+1 i_Pclk after the i_Sclk pin rise.
- A start bit arriving in the same sample event that IDLE is re-entered is not accepted; the earliest next start is the following sample event.

Test Plan:
- Reset, then frame 0x2E with i_ParEn = 0 (start 0; bits 0,1,1,1,0,1,0,0; stop 1) → one o_Push pulse with o_Data = 0x2E; o_ParErr = o_FrmErr = o_Ovr = 0; o_Busy low after the frame.
- i_ParEn = 1, i_ParOdd = 0, frame 0x2E with parity bit 0 → push 0x2E, o_ParErr = 0. Repeat with parity bit 1 → push 0x2E, o_ParErr = 1.
- Frame 0xA5 with stop bit 0, then Rxd held low for 3 more bit clocks, then high → no push, o_FrmErr = 1. No new frame is started until a 1 has been sampled. A following 0x3C frame pushes 0x3C and clears o_FrmErr.
- i_Full = 1 during frame 0x55 → no push, o_Ovr = 1, o_Data keeps its prior value. Pulse i_ClrOvr → o_Ovr = 0. With i_Full = 0, frame 0x55 → push 0x55.
- Drive i_Reset low after 4 data bits of 0xFF, release it, then send 0x81 → no push for the aborted frame; the single push carries 0x81.
- Two back-to-back frames 0x01, 0x80 with no idle bit between → two pushes in order 0x01, 0x80, each exactly one i_Pclk wide.
